// File: rtl/cellrv32_bus_gateway_pkg.sv
// Shared types and helpers for the p_bus responder-side gateway.
package cellrv32_bus_gateway_pkg;

    typedef enum logic [1:0] {
        GW_IDLE,
        GW_BUSY,
        GW_ERR
    } gw_state_t;

    localparam logic [1:0] GW_REG_IMEM = 2'd0;
    localparam logic [1:0] GW_REG_DMEM = 2'd1;
    localparam logic [1:0] GW_REG_IO   = 2'd2;
    localparam logic [1:0] GW_REG_EXT  = 2'd3;

    // Region base must be aligned to its power-of-two size.
    function automatic logic gw_hit(input logic [31:0] addr, input logic [31:0] base,
                                    input int unsigned size);
        return (addr & ~(size - 32'd1)) == base;
    endfunction

endpackage

// File: rtl/cellrv32_bus_gateway_if.sv
// Host-side and region-side signal bundle of the bus gateway.
interface cellrv32_bus_gateway_if;

    logic             h_priv;
    logic [31:0]      h_addr;
    logic [31:0]      h_wdata;
    logic [3:0]       h_ben;
    logic             h_we;
    logic             h_re;
    logic [31:0]      h_rdata;
    logic             h_ack;
    logic             h_err;

    logic             r_priv;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_ben;
    logic [3:0]       r_we;
    logic [3:0]       r_re;
    logic [3:0][31:0] r_rdata;
    logic [3:0]       r_ack;
    logic [3:0]       r_err;

    modport slave (
        input  h_priv, h_addr, h_wdata, h_ben, h_we, h_re,
        output h_rdata, h_ack, h_err,
        output r_priv, r_addr, r_wdata, r_ben, r_we, r_re,
        input  r_rdata, r_ack, r_err
    );

    modport master (
        output h_priv, h_addr, h_wdata, h_ben, h_we, h_re,
        input  h_rdata, h_ack, h_err,
        input  r_priv, r_addr, r_wdata, r_ben, r_we, r_re,
        output r_rdata, r_ack, r_err
    );

endinterface

// File: rtl/cellrv32_bus_gateway.sv
// Responder-side p_bus gateway: decodes one host access onto IMEM/DMEM/IO/EXT and
// returns exactly one ack or err (unmapped, read-only write and timeout end in err).
//
// state   | meaning
// --------+---------------------------------------------------------
// GW_IDLE | waiting for a host re/we pulse; legal access forwarded here
// GW_BUSY | access forwarded to region sel_q, awaiting ack/err/timeout
// GW_ERR  | illegal access, signal h_err for one cycle
module cellrv32_bus_gateway
    import cellrv32_bus_gateway_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE = 32'h0000_0000,
    parameter int unsigned IMEM_SIZE = 16384,
    parameter bit          IMEM_RO   = 1'b1,
    parameter logic [31:0] DMEM_BASE = 32'h8000_0000,
    parameter int unsigned DMEM_SIZE = 8192,
    parameter logic [31:0] IO_BASE   = 32'hFFFF_FE00,
    parameter int unsigned IO_SIZE   = 512,
    parameter bit          EXT_EN    = 1'b1,
    parameter int unsigned TIMEOUT   = 15
) (
    input logic                   clk_i,
    input logic                   rstn_i,
    cellrv32_bus_gateway_if.slave bus
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    gw_state_t        state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       dec_sel;
    logic             dec_ok;
    logic             dec_illegal;

    assign bus.r_priv  = bus.h_priv;
    assign bus.r_addr  = bus.h_addr;
    assign bus.r_wdata = bus.h_wdata;
    assign bus.r_ben   = bus.h_ben;

    // Checked from highest to lowest index so the lowest matching region wins.
    always_comb begin
        dec_sel = GW_REG_EXT;
        dec_ok  = EXT_EN;
        if (gw_hit(bus.h_addr, IO_BASE, IO_SIZE)) begin
            dec_sel = GW_REG_IO;
            dec_ok  = 1'b1;
        end
        if (gw_hit(bus.h_addr, DMEM_BASE, DMEM_SIZE)) begin
            dec_sel = GW_REG_DMEM;
            dec_ok  = 1'b1;
        end
        if (gw_hit(bus.h_addr, IMEM_BASE, IMEM_SIZE)) begin
            dec_sel = GW_REG_IMEM;
            dec_ok  = 1'b1;
        end
        dec_illegal = !dec_ok || (bus.h_we && IMEM_RO && (dec_sel == GW_REG_IMEM));
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        bus.h_ack   = 1'b0;
        bus.h_err   = 1'b0;
        bus.h_rdata = '0;
        bus.r_we    = '0;
        bus.r_re    = '0;
        case (state_q)
            GW_IDLE: begin
                if (bus.h_re || bus.h_we) begin
                    if (dec_illegal) begin
                        state_d = GW_ERR;
                    end else begin
                        sel_d   = dec_sel;
                        cnt_d   = '0;
                        state_d = GW_BUSY;
                        if (bus.h_we) bus.r_we[dec_sel] = 1'b1;
                        else          bus.r_re[dec_sel] = 1'b1;
                    end
                end
            end
            GW_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.r_err[sel_q]) begin
                    bus.h_err = 1'b1;
                    state_d   = GW_IDLE;
                end else if (bus.r_ack[sel_q]) begin
                    bus.h_ack   = 1'b1;
                    bus.h_rdata = bus.r_rdata[sel_q];
                    state_d     = GW_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    bus.h_err = 1'b1;
                    state_d   = GW_IDLE;
                end
            end
            GW_ERR: begin
                bus.h_err = 1'b1;
                state_d   = GW_IDLE;
            end
            default: state_d = GW_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= GW_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
